// File: rtl/chunked_comparator.sv
// rtl/chunked_comparator.sv - multi-cycle chunked magnitude/equality comparator
// Compares MSB chunk first and stops at the first differing chunk; result held until accepted.
module chunked_comparator #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       Opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       comp_out,
   output logic             eq_flag,
   output logic             gt_flag,
   output logic             lt_flag
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       op_q;
   logic [IW-1:0]    idx_q;
   logic             in_ready_q, out_valid_q;
   logic [3:0]       comp_q;
   logic             eq_q, gt_q, lt_q;

   logic [WIDTH-1:0] sa_d, sb_d;
   logic [CHUNK-1:0] ca_d, cb_d;
   logic             is_signed_d, chunk_gt_d, chunk_lt_d, res_d;

   always_comb begin
      is_signed_d = (op_q == 4'b1110) || (op_q == 4'b1111);
      sa_d = a_q >> (int'(idx_q) * CHUNK);
      sb_d = b_q >> (int'(idx_q) * CHUNK);
      ca_d = sa_d[CHUNK-1:0];
      cb_d = sb_d[CHUNK-1:0];
      // Flipping the sign bit maps two's complement order onto unsigned order.
      if (is_signed_d && (idx_q == TOP_IDX)) begin
         ca_d[CHUNK-1] = ~ca_d[CHUNK-1];
         cb_d[CHUNK-1] = ~cb_d[CHUNK-1];
      end
      chunk_gt_d = ca_d > cb_d;
      chunk_lt_d = ca_d < cb_d;
      case (op_q)
         4'b1100:          res_d = ~(chunk_gt_d | chunk_lt_d);
         4'b1101:          res_d = chunk_gt_d | chunk_lt_d;
         4'b1110, 4'b1010: res_d = chunk_gt_d;
         4'b1111, 4'b1011: res_d = chunk_lt_d;
         default:          res_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         comp_q      <= '0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= A;
                  b_q        <= B;
                  op_q       <= Opcode;
                  idx_q      <= TOP_IDX;
                  in_ready_q <= 1'b0;
                  state_q    <= CMP;
               end
            end
            CMP: begin
               if (chunk_gt_d || chunk_lt_d || (idx_q == '0)) begin
                  eq_q        <= ~(chunk_gt_d | chunk_lt_d);
                  gt_q        <= chunk_gt_d;
                  lt_q        <= chunk_lt_d;
                  comp_q      <= {3'b000, res_d};
                  out_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            RESP: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign comp_out  = comp_q;
   assign eq_flag   = eq_q;
   assign gt_flag   = gt_q;
   assign lt_flag   = lt_q;

endmodule

// File: tb/tb_chunked_comparator.sv
// tb/tb_chunked_comparator.sv - bench for chunked_comparator at CHUNK=4, 1 and 16
module tb_chunked_comparator;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [2:0]  iv;
   logic [15:0] a, b;
   logic [3:0]  op;
   logic        out_ready;
   int checks = 0;
   int failures = 0;

   logic ir0, ir1, ir2, ov0, ov1, ov2, eq0, eq1, eq2, gt0, gt1, gt2, lt0, lt1, lt2;
   logic [3:0] co0, co1, co2;
   logic [2:0] ir, ov, eqf, gtf, ltf;
   logic [11:0] co;
   assign ir  = {ir2, ir1, ir0};
   assign ov  = {ov2, ov1, ov0};
   assign eqf = {eq2, eq1, eq0};
   assign gtf = {gt2, gt1, gt0};
   assign ltf = {lt2, lt1, lt0};
   assign co  = {co2, co1, co0};

   chunked_comparator #(.WIDTH(16), .CHUNK(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir0), .A(a), .B(b), .Opcode(op),
      .out_valid(ov0), .out_ready(out_ready), .comp_out(co0), .eq_flag(eq0), .gt_flag(gt0), .lt_flag(lt0));
   chunked_comparator #(.WIDTH(16), .CHUNK(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir1), .A(a), .B(b), .Opcode(op),
      .out_valid(ov1), .out_ready(out_ready), .comp_out(co1), .eq_flag(eq1), .gt_flag(gt1), .lt_flag(lt1));
   chunked_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir2), .A(a), .B(b), .Opcode(op),
      .out_valid(ov2), .out_ready(out_ready), .comp_out(co2), .eq_flag(eq2), .gt_flag(gt2), .lt_flag(lt2));

   // One transaction on instance w; hold > 0 applies backpressure with input noise for hold cycles.
   task automatic run_txn(input int w, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [3:0] top, input int hold, input string tag);
      int chunk, nchunk, msb, lat, cyc;
      logic e_eq, e_gt, e_lt, e_res;
      logic [15:0] x;
      logic [3:0] got_co;
      chunk  = (w == 0) ? 4 : (w == 1) ? 1 : 16;
      nchunk = 16 / chunk;
      e_eq = (ta == tb_v);
      if (top == 4'b1110 || top == 4'b1111) e_gt = $signed(ta) > $signed(tb_v);
      else e_gt = ta > tb_v;
      e_lt = !e_eq && !e_gt;
      case (top)
         4'b1100: e_res = e_eq;
         4'b1101: e_res = !e_eq;
         4'b1110, 4'b1010: e_res = e_gt;
         4'b1111, 4'b1011: e_res = e_lt;
         default: e_res = 1'b0;
      endcase
      x = ta ^ tb_v;
      msb = -1;
      for (int i = 15; i >= 0; i--) if (x[i] && msb < 0) msb = i;
      lat = e_eq ? nchunk : nchunk - msb / chunk;

      a = ta; b = tb_v; op = top; iv[w] = 1'b1;
      @(posedge clk); #1;
      iv[w] = 1'b0;
      checks++;
      if (ir[w] !== 1'b0) begin failures++; $display("FAIL %s in_ready_after_accept got=%b want=0", tag, ir[w]); end
      cyc = 0;
      while (ov[w] !== 1'b1 && cyc < 40) begin
         a = 16'($urandom); b = 16'($urandom); op = 4'($urandom); iv[w] = 1'($urandom);
         @(posedge clk); #1;
         cyc++;
      end
      iv[w] = 1'b0;
      got_co = co[w*4 +: 4];
      checks++;
      if (cyc !== lat) begin failures++; $display("FAIL %s latency got=%0d want=%0d", tag, cyc, lat); end
      checks++;
      if (got_co !== {3'b000, e_res}) begin failures++; $display("FAIL %s comp_out got=%b want=%b", tag, got_co, {3'b000, e_res}); end
      checks++;
      if ({eqf[w], gtf[w], ltf[w]} !== {e_eq, e_gt, e_lt}) begin
         failures++; $display("FAIL %s flags eq/gt/lt got=%b%b%b want=%b%b%b", tag, eqf[w], gtf[w], ltf[w], e_eq, e_gt, e_lt);
      end
      for (int h = 0; h < hold; h++) begin
         a = 16'($urandom); b = 16'($urandom); op = 4'($urandom); iv[w] = 1'($urandom);
         @(posedge clk); #1;
         got_co = co[w*4 +: 4];
         checks++;
         if ({ov[w], ir[w], got_co, eqf[w], gtf[w], ltf[w]} !== {1'b1, 1'b0, 3'b000, e_res, e_eq, e_gt, e_lt}) begin
            failures++;
            $display("FAIL %s hold%0d ov/ir/co/flags got=%b %b %b %b%b%b want=1 0 %b %b%b%b", tag, h, ov[w], ir[w], got_co,
                     eqf[w], gtf[w], ltf[w], {3'b000, e_res}, e_eq, e_gt, e_lt);
         end
      end
      iv[w] = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if ({ov[w], ir[w]} !== 2'b01) begin failures++; $display("FAIL %s after_handshake ov/ir got=%b%b want=01", tag, ov[w], ir[w]); end
   endtask

   task automatic test_reset();
      reset = 1'b1; iv = '0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int w = 0; w < 3; w++) begin
         checks++;
         if ({ir[w], ov[w], co[w*4 +: 4], eqf[w], gtf[w], ltf[w]} !== 9'b1_0_0000_000) begin
            failures++;
            $display("FAIL reset_state inst%0d ir/ov/co/eq/gt/lt got=%b%b %b %b%b%b want=10 0000 000", w, ir[w], ov[w],
                     co[w*4 +: 4], eqf[w], gtf[w], ltf[w]);
         end
      end
   endtask

   task automatic test_directed();
      run_txn(0, 16'h1234, 16'h1234, 4'b1100, 0, "eq_equal");
      run_txn(0, 16'h7FFF, 16'h8000, 4'b1110, 0, "gt_signed");
      run_txn(0, 16'h7FFF, 16'h8000, 4'b1010, 0, "gt_unsigned");
      run_txn(0, 16'h1230, 16'h1231, 4'b1111, 0, "lt_signed_low");
      run_txn(0, 16'h0005, 16'h0003, 4'b0000, 0, "bad_opcode");
      run_txn(0, 16'h1234, 16'h1235, 4'b1101, 0, "ne");
   endtask

   task automatic test_backpressure();
      run_txn(0, 16'h1234, 16'h1234, 4'b1100, 5, "backpressure");
   endtask

   task automatic test_reset_mid();
      a = 16'hFFFF; b = 16'hFFFF; op = 4'b1100; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({ir[0], ov[0], co[3:0], eqf[0], gtf[0], ltf[0]} !== 9'b1_0_0000_000) begin
         failures++;
         $display("FAIL reset_mid ir/ov/co/flags got=%b%b %b %b%b%b want=10 0000 000", ir[0], ov[0], co[3:0], eqf[0], gtf[0], ltf[0]);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (ov[0] !== 1'b0) begin failures++; $display("FAIL reset_mid_no_result ov got=%b want=0", ov[0]); end
      run_txn(0, 16'hFFFF, 16'hFFFE, 4'b1011, 0, "after_reset");
   endtask

   task automatic test_chunk_variants();
      run_txn(1, 16'h7FFF, 16'h8000, 4'b1110, 0, "gt_signed_chunk1");
      run_txn(2, 16'h7FFF, 16'h8000, 4'b1110, 0, "gt_signed_chunk16");
      run_txn(1, 16'h1234, 16'h1234, 4'b1100, 0, "eq_chunk1");
      run_txn(2, 16'h1234, 16'h1234, 4'b1100, 2, "eq_chunk16");
   endtask

   task automatic test_random();
      logic [3:0] ops [8];
      logic [15:0] ra, rb;
      ops = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1010, 4'b1011, 4'b0000, 4'b0111};
      for (int w = 0; w < 3; w++) begin
         for (int n = 0; n < 40; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
               0: rb = ra;
               1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
               default: rb = 16'($urandom);
            endcase
            run_txn(w, ra, rb, ops[$urandom_range(0, 7)], $urandom_range(0, 2), $sformatf("rand_i%0d_n%0d", w, n));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_chunk_variants();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
